gate_tt_checker: RTL and testbench
==================================

Name: gate_tt_checker

Overview:
Self-checking truth-table sequencer for small combinational gates (nand/nor/xor etc.) in the gate library. On a start pulse it walks all 2^N_IN input vectors into the gate under test and holds each vector for a settle window. It then samples the gate output and compares it against a parameterised expected truth table. It reports the mismatch count, the first failing vector, and pass/done status, so gate checks can run on-chip or under a bench without hand-written $display sequences.

Parameters:
N_IN, 2, number of gate inputs (1..4); vector width.
SETTLE, 2, cycles each vector is held before sampling (>=1).
EXP_TT, 4'b0111, expected output per vector; bit i = expected y for vec_out==i; width 2**N_IN. Default is 2-input NAND.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  begin a sweep; sampled only in IDLE.
abort  input  1  synchronous cancel of a running sweep.
vec_out  output  N_IN  input vector driven to gate under test; MSB = first gate input (a).
y_in  input  1  gate-under-test output.
busy  output  1  high from the cycle after start is accepted until DONE or abort.
done  output  1  one-cycle pulse at sweep completion.
pass  output  1  1 when last completed sweep had err_cnt==0; held until next accepted start.
err_cnt  output  N_IN+1  mismatch count of current/last sweep; saturates cannot occur (max 2^N_IN).
fail_vec  output  N_IN  first mismatching vector of current/last sweep.
fail_valid  output  1  fail_vec holds a valid value.

Behaviour:
- Reset (async, rst=1): state IDLE; vec_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, fail_valid=0, settle counter=0. Applies immediately, including mid-sweep.
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE: start=1 -> APPLY. On that edge: vec_out<=0, err_cnt<=0, fail_valid<=0, fail_vec<=0, pass<=0, settle counter<=SETTLE-1, busy<=1.
- APPLY: vec_out stable. The counter decrements each cycle. At counter==0 -> CHECK. Duration: exactly SETTLE cycles.
- CHECK: one cycle. y_in is sampled on the clock edge leaving CHECK and compared with EXP_TT[vec_out].
  - Mismatch: err_cnt+1. If fail_valid==0, fail_vec<=vec_out and fail_valid<=1.
  - If vec_out==2^N_IN-1 -> DONE.
  - Otherwise vec_out<=vec_out+1, counter reloaded to SETTLE-1, -> APPLY.
- Each vector occupies SETTLE+1 cycles. A full sweep is 2^N_IN*(SETTLE+1) cycles from the start-accept edge to the DONE entry edge.
- DONE: one cycle. done=1, busy=0. pass<=(err_cnt==0) is registered on entering DONE, including the final CHECK result. Then -> IDLE. vec_out holds the last vector until the next start.
- abort=1 in APPLY/CHECK: -> IDLE next edge. busy<=0, no done pulse, pass stays 0. err_cnt/fail_vec keep their partial values. abort has priority over the CHECK-cycle update: the CHECK sample is discarded. abort in IDLE/DONE is ignored.
- start while busy or in DONE is ignored (no restart, no counter disturbance).
- start and abort both high in IDLE: start is accepted and abort ignored.
- vec_out is registered (no combinational path from start). y_in is used only in CHECK, so X on y_in outside CHECK has no effect.
- err_cnt width N_IN+1 holds 2^N_IN without wrap.

Test Plan:
- Correct NAND model, defaults, start pulse at cycle 0 -> vec_out sequence 00,01,10,11 each held 3 cycles; done pulse after 12 cycles; pass=1, err_cnt=0, fail_valid=0.
- AND model in place of NAND -> all 4 vectors mismatch; err_cnt=4, fail_vec=2'b00, fail_valid=1, pass=0.
- y_in stuck at 1 -> only vector 11 mismatches; err_cnt=1, fail_vec=2'b11, pass=0.
- start re-pulsed during vector 01 -> sweep is unaffected; single done pulse at the original time. A second start after done -> err_cnt/pass clear and a fresh 12-cycle sweep runs.
- abort asserted in CHECK of vector 10 with a faulty model -> IDLE next cycle; no done; busy=0; vector-10 result not counted.
- rst asserted asynchronously mid-APPLY of vector 01 -> all outputs 0 immediately, before the next clk edge; after release, start yields a normal 12-cycle sweep.

Source files
------------

// File: rtl/gate_tt_checker.sv
// Truth-table sequencer: sweeps every input vector into a gate under test and compares its output with EXP_TT.
// Each vector is held SETTLE cycles and then checked for one cycle.
module gate_tt_checker #(
    parameter int                  N_IN   = 2,
    parameter int                  SETTLE = 2,
    parameter logic [2**N_IN-1:0]  EXP_TT = 4'b0111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   vec_out,
    input  logic              y_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_cnt,
    output logic [N_IN-1:0]   fail_vec,
    output logic              fail_valid
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC    = N_IN'(2**N_IN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          mismatch;
    logic [N_IN:0] err_next;

    // y_in only matters in CHECK; both signals are ignored in every other state.
    always_comb begin
        mismatch = (y_in != EXP_TT[vec_out]);
        err_next = err_cnt + (N_IN + 1)'(mismatch);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            vec_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_APPLY;
                        vec_out    <= '0;
                        err_cnt    <= '0;
                        fail_vec   <= '0;
                        fail_valid <= 1'b0;
                        pass       <= 1'b0;
                        cnt        <= SETTLE_LOAD;
                        busy       <= 1'b1;
                    end
                end
                S_APPLY: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_CHECK: begin
                    // abort wins: the sample of this cycle is dropped
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        err_cnt <= err_next;
                        if (mismatch && !fail_valid) begin
                            fail_vec   <= vec_out;
                            fail_valid <= 1'b1;
                        end
                        if (vec_out == LAST_VEC) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else begin
                            vec_out <= vec_out + N_IN'(1);
                            cnt     <= SETTLE_LOAD;
                            state   <= S_APPLY;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: a table-driven gate model feeds y_in; expectations come from a per-vector timing/count model.
module tb_gate_tt_checker;

    localparam logic [3:0] EXP     = 4'b0111;
    localparam int         PER_VEC = 3;
    localparam int         SWEEP   = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] vec_out;
    logic       y_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [1:0] fail_vec;
    logic       fail_valid;

    logic [3:0] gut;
    int n_assert = 0;
    int n_fail   = 0;

    assign y_in = gut[vec_out];

    gate_tt_checker dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .vec_out    (vec_out),
        .y_in       (y_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .fail_vec   (fail_vec),
        .fail_valid (fail_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mismatches among the first n vectors when the gate behaves as table g.
    function automatic int model_err(input logic [3:0] g, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (g[i] != EXP[i]) c++;
        return c;
    endfunction

    function automatic int model_first(input logic [3:0] g, input int n);
        for (int i = 0; i < n; i++) if (g[i] != EXP[i]) return i;
        return 0;
    endfunction

    task automatic run_sweep(input logic [3:0] g, input int restart_at, input int abort_at, input bit both);
        int nv;
        gut   = g;
        start = 1'b1;
        abort = both;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < SWEEP; k++) begin
            chk("vec_out", 32'(vec_out), k / PER_VEC);
            chk("busy", 32'(busy), 1);
            chk("done", 32'(done), 0);
            chk("pass_cleared", 32'(pass), 0);
            start = (k == restart_at);
            abort = (k == abort_at);
            tick();
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                nv = k / PER_VEC;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_err", 32'(err_cnt), model_err(g, nv));
                chk("abort_fvalid", 32'(fail_valid), model_err(g, nv) != 0);
                chk("abort_fvec", 32'(fail_vec), model_first(g, nv));
                for (int j = 0; j < 4; j++) begin
                    abort = (j == 1);
                    chk("abort_no_done", 32'(done), 0);
                    chk("abort_pass", 32'(pass), 0);
                    chk("abort_idle", 32'(busy), 0);
                    tick();
                end
                abort = 1'b0;
                return;
            end
        end
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_pass", 32'(pass), model_err(g, 4) == 0);
        chk("done_err", 32'(err_cnt), model_err(g, 4));
        chk("done_fvalid", 32'(fail_valid), model_err(g, 4) != 0);
        chk("done_fvec", 32'(fail_vec), model_first(g, 4));
        tick();
        chk("done_one_cycle", 32'(done), 0);
        chk("vec_hold", 32'(vec_out), 3);
        chk("pass_hold", 32'(pass), model_err(g, 4) == 0);
        tick();
    endtask

    initial begin
        int ab;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        gut   = EXP;
        tick();
        chk("rst_vec", 32'(vec_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_fvalid", 32'(fail_valid), 0);
        rst = 1'b0;
        tick();

        run_sweep(4'b0111, -1, -1, 1'b0);   // correct NAND
        run_sweep(4'b1000, -1, -1, 1'b0);   // AND instead of NAND
        run_sweep(4'b1111, -1, -1, 1'b0);   // stuck at 1
        run_sweep(4'b0111, 4, -1, 1'b0);    // start re-pulsed during vector 01
        run_sweep(4'b1000, -1, 8, 1'b0);    // abort in CHECK of vector 10
        run_sweep(4'b0111, -1, -1, 1'b1);   // start and abort together in IDLE

        // asynchronous reset in the middle of vector 01
        gut   = 4'b1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_err", 32'(err_cnt), 1);
        rst = 1'b1;
        #2;
        chk("arst_vec", 32'(vec_out), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_err", 32'(err_cnt), 0);
        chk("arst_fvalid", 32'(fail_valid), 0);
        chk("arst_fvec", 32'(fail_vec), 0);
        tick();
        rst = 1'b0;
        tick();
        run_sweep(4'b0111, -1, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            ab = $urandom_range(0, 17);
            run_sweep(4'($urandom), -1, (ab < SWEEP) ? ab : -1, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
